// File: rtl/rv_trace_tx.sv
`timescale 1ns/1ps
// rv_trace_tx -- retire-trace transmitter for the FlexRV32 core.
//
// Captures one retired-instruction record per cycle from write-back, buffers
// it in a small record FIFO and serializes each record as a 3..6 word packet
// on a valid/ready stream:
//   HDR, PC, INSTR, [RD], [MADDR, MDATA]
// Header: [31:24]=0xA5, [23]=mem_read, [22]=mem_write, [21]=reg_write,
//         [20]=lost, [19:16]=mem_sel (0 without a memory op), [15:8]=seq,
//         [7:0]=packet length in words.
// Records arriving while the FIFO is full are dropped, counted in a
// saturating counter, and flagged on the next accepted record via 'lost'.
//
// Ports:
//   i_clk, i_reset_n        clock, asynchronous active-low reset
//   i_retire_valid          a record is presented this cycle
//   i_pc .. i_mem_sel       record fields from write-back
//   o_tx_data/valid/last    packet stream, i_tx_ready is the consumer ready
//   o_overflow_cnt          saturating count of dropped records
//   o_busy                  FIFO not empty or a packet in flight
module rv_trace_tx #(
    parameter int unsigned IADDR_SPACE_BITS = 32,
    parameter int unsigned FIFO_DEPTH       = 8
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_retire_valid,
    input  logic [IADDR_SPACE_BITS-1:0] i_pc,
    input  logic [31:0]                 i_instr,
    input  logic                        i_reg_write,
    input  logic [31:0]                 i_rd_data,
    input  logic                        i_mem_read,
    input  logic                        i_mem_write,
    input  logic [31:0]                 i_mem_addr,
    input  logic [31:0]                 i_mem_data,
    input  logic [3:0]                  i_mem_sel,
    output logic [31:0]                 o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_tx_last,
    output logic [15:0]                 o_overflow_cnt,
    output logic                        o_busy
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rv_trace_tx: FIFO_DEPTH must be a power of two and at least 2");
    end

    // One buffered retire record; PC is already zero-extended to 32 bits.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        reg_write;
        logic [31:0] rd_data;
        logic        mem_read;
        logic        mem_write;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [3:0]  mem_sel;
        logic [7:0]  seq;
        logic        lost;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_INSTR,
        S_RD,
        S_MADDR,
        S_MDATA
    } state_t;

    // ------------------------------------------------------------------
    // Capture side: sequence number, drop accounting, FIFO write
    // ------------------------------------------------------------------
    logic [7:0]   seq;
    logic         lost;
    logic [15:0]  overflow_cnt;

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    logic           fifo_empty;
    logic           fifo_full;
    logic           push;
    logic           pop;
    rec_t           in_rec;
    rec_t           fifo_mem [FIFO_DEPTH];

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // Full is judged on the registered pointers, so a same-edge pop never
    // makes room for a write to a full FIFO.
    assign push = i_retire_valid && !fifo_full;

    always_comb begin
        in_rec           = '0;
        in_rec.pc        = 32'(i_pc);
        in_rec.instr     = i_instr;
        in_rec.reg_write = i_reg_write;
        in_rec.rd_data   = i_rd_data;
        in_rec.mem_read  = i_mem_read;
        in_rec.mem_write = i_mem_write;
        in_rec.mem_addr  = i_mem_addr;
        in_rec.mem_data  = i_mem_data;
        in_rec.mem_sel   = i_mem_sel;
        in_rec.seq       = seq;
        in_rec.lost      = lost;
    end

    // seq advances on every retire, accepted or dropped; lost is sticky
    // until an accepted record has carried it out.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            seq          <= '0;
            lost         <= 1'b0;
            overflow_cnt <= '0;
        end else if (i_retire_valid) begin
            seq <= seq + 8'd1;
            if (fifo_full) begin
                lost <= 1'b1;
                if (overflow_cnt != '1) begin
                    overflow_cnt <= overflow_cnt + 16'd1;
                end
            end else begin
                lost <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Record storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= in_rec;
        end
    end

    // ------------------------------------------------------------------
    // Transmit side: holding register and packet FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_next;
    rec_t        hold;
    logic        hold_mem;
    logic [7:0]  pkt_len;
    logic [31:0] hdr_word;
    logic        handshake;
    logic [31:0] tx_data;
    logic        tx_last;

    assign hold_mem = hold.mem_read || hold.mem_write;
    assign pkt_len  = 8'd3 + 8'(hold.reg_write) + (hold_mem ? 8'd2 : 8'd0);
    assign hdr_word = {8'hA5, hold.mem_read, hold.mem_write, hold.reg_write,
                       hold.lost, (hold_mem ? hold.mem_sel : 4'h0),
                       hold.seq, pkt_len};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (pop) begin
                hold <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    // Word mux, last flag and next-state all derive from registered state
    // and the holding register; i_tx_ready only steers the transition.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_data    = '0;
        tx_last    = 1'b0;
        handshake  = (state != S_IDLE) && i_tx_ready;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_HDR;
                end
            end
            S_HDR: begin
                tx_data = hdr_word;
                if (handshake) begin
                    state_next = S_PC;
                end
            end
            S_PC: begin
                tx_data = hold.pc;
                if (handshake) begin
                    state_next = S_INSTR;
                end
            end
            S_INSTR: begin
                tx_data = hold.instr;
                tx_last = !hold.reg_write && !hold_mem;
                if (handshake && !tx_last) begin
                    state_next = hold.reg_write ? S_RD : S_MADDR;
                end
            end
            S_RD: begin
                tx_data = hold.rd_data;
                tx_last = !hold_mem;
                if (handshake && !tx_last) begin
                    state_next = S_MADDR;
                end
            end
            S_MADDR: begin
                tx_data = hold.mem_addr;
                if (handshake) begin
                    state_next = S_MDATA;
                end
            end
            S_MDATA: begin
                tx_data = hold.mem_data;
                tx_last = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // End of packet: chain straight into the next header when a record
        // is waiting, so back-to-back packets have no idle cycle.
        if (handshake && tx_last) begin
            if (!fifo_empty) begin
                pop        = 1'b1;
                state_next = S_HDR;
            end else begin
                state_next = S_IDLE;
            end
        end
    end

    assign o_tx_data      = tx_data;
    assign o_tx_valid     = (state != S_IDLE);
    assign o_tx_last      = tx_last;
    assign o_overflow_cnt = overflow_cnt;
    assign o_busy         = !fifo_empty || (state != S_IDLE);

endmodule
